fifo_write_logic: RTL and testbench
===================================

Name: fifo_write_logic

Overview:
Write-side control for the dual-clock FIFO, and the counterpart of the FIFO read-side controller. Runs in the write clock domain and accepts producer write requests. Generates the memory write strobe and the write address, and publishes a Gray-coded write pointer for synchronisation into the read domain. Detects full and almost-full against a read pointer that has already been synchronised into the write domain.

Parameters:
DEPTH, 3, number of FIFO entries; addresses count modulo DEPTH; one slot is always kept empty, so usable capacity is DEPTH-1
PTR_SZ, 2, width in bits of the address and pointers; requires 2^PTR_SZ >= DEPTH
AFULL_THRESH, 1, occupancy (in entries) at or above which walmost_full asserts; legal range 1..DEPTH-1

Ports:
clk  in  1  write-domain clock, rising edge
rst  in  1  asynchronous active-low reset
winc  in  1  producer write request; the data is valid in the same cycle
wq2_raddr_gray  in  PTR_SZ  read pointer, Gray-coded, already double-synchronised into clk
write_en  out  1  memory write strobe, combinational: winc && !wfull
waddr  out  PTR_SZ  binary write address, registered
waddr_gray  out  PTR_SZ  Gray code of waddr, registered: waddr ^ (waddr >> 1)
wfull  out  1  FIFO full, registered
walmost_full  out  1  occupancy >= AFULL_THRESH, registered
wbusy  out  1  high while the FSM is in WRITE, registered
woverflow  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): waddr=0, waddr_gray=0, wfull=0, walmost_full=0, wbusy=0, woverflow=0, FSM=IDLE. The release of reset is synchronous to clk.
- Read-pointer decode, combinational: rbin[i] = XOR of wq2_raddr_gray[PTR_SZ-1:i], for i = 0..PTR_SZ-1.
- Accept: a write is accepted when winc=1 and wfull=0. write_en equals the accept, combinationally. The memory writes at the current waddr.
- Pointer update, on an accepted write: waddr <= (waddr+1) % DEPTH, and waddr_gray follows in the same edge. Otherwise both hold. Zero-latency accept; the new address is visible one cycle later.
- Pointer wrap: when waddr = DEPTH-1 and the write is accepted, waddr becomes 0.
- Full: on each edge, wfull <= ((wnext+1) % DEPTH == rbin), where wnext is the value waddr takes at that edge. Full therefore asserts in the cycle after the write that fills the last usable slot.
- Leaving full: when the read pointer advances, wfull deasserts on the first edge after wq2_raddr_gray changes.
- Write while full: winc=1 with wfull=1 is dropped. write_en=0, waddr holds, no error beyond woverflow.
- Simultaneous write and read-pointer change: both take effect in the same edge's full computation (wnext together with the new rbin).
- Occupancy: count = (wnext - rbin + DEPTH) % DEPTH. walmost_full <= (count >= AFULL_THRESH).
- FSM states, held in a registered 2-bit state:
  - IDLE -> WRITE on an accepted write.
  - WRITE -> FULL when the next wfull is 1.
  - WRITE -> IDLE when no write is accepted and the FIFO is not full.
  - WRITE -> WRITE on an accepted write that does not fill the FIFO.
  - FULL -> WRITE when the next wfull is 0 and winc=1.
  - FULL -> IDLE when the next wfull is 0 and winc=0.
  - FULL -> FULL otherwise.
  - Unused encoding -> IDLE.
- wbusy is 1 exactly when the registered state is WRITE.
- Reset mid-operation: all outputs return to their reset values immediately. In-flight writes are lost.

Optional Feature:
- Macro: FIFO_WR_OVERFLOW_EN.
- Defined: woverflow is set on the first edge on which winc=1 and wfull=1. It is sticky until rst.
- Undefined: the woverflow port still exists, tied to 0, and no overflow logic is synthesised.

Decomposition:
- Shared package fifo_pkg holds:
  - the FSM state localparams (IDLE=2'b00, WRITE=2'b01, FULL=2'b10);
  - Gray encode and decode functions, bin2gray and gray2bin, sized by PTR_SZ;
  - these are also reused by the read-side controller.
- One sub-module is natural: fifo_gray2bin, the combinational Gray-to-binary converter instantiated on wq2_raddr_gray. Everything else stays in the top module.

Test Plan:
All scenarios use DEPTH=3, PTR_SZ=2, AFULL_THRESH=1, with the macro defined.
- Reset: assert rst=0 mid-run -> all outputs 0 asynchronously. Release with winc=0 -> outputs stay 0 and wbusy=0.
- Fill with read pointer held at 0: winc=1 for 3 cycles.
  - waddr goes 0 -> 1 -> 2.
  - waddr_gray goes 00 -> 01 -> 11.
  - wfull=1 after the 2nd accepted write.
  - 3rd write: write_en=0, waddr holds at 2, woverflow=1.
  - FSM goes IDLE -> WRITE -> FULL.
- Drain release: from full, set wq2_raddr_gray=01 -> wfull=0 the next cycle. winc=1 then writes at addr 2, waddr wraps to 0, and wfull=1 again.
- Almost full: starting empty, one write -> walmost_full=1. Then raddr_gray=01 -> walmost_full=0 the next cycle.
- Simultaneous: when full, present winc=1 in the same cycle the read pointer advances. The write is not accepted that cycle (wfull still 1), and is accepted on the following cycle.
- Macro undefined: overflow attempt -> woverflow stays 0, and all other responses are unchanged.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: controller state encoding and Gray conversion helpers,
// used by both the write-side and read-side controllers.
package fifo_pkg;

  // Helpers work at this width; callers zero-extend and truncate to their pointer size.
  localparam int unsigned FIFO_PTR_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    FULL  = 2'b10
  } fifo_state_e;

  function automatic logic [FIFO_PTR_MAX-1:0] bin2gray(input logic [FIFO_PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FIFO_PTR_MAX-1:0] gray2bin(input logic [FIFO_PTR_MAX-1:0] g);
    logic [FIFO_PTR_MAX-1:0] b;
    b[FIFO_PTR_MAX-1] = g[FIFO_PTR_MAX-1];
    for (int i = FIFO_PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter for a synchronised FIFO pointer.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_SZ = 2
) (
  input  logic [PTR_SZ-1:0] i_gray,
  output logic [PTR_SZ-1:0] o_bin
);

  assign o_bin = PTR_SZ'(gray2bin(FIFO_PTR_MAX'(i_gray)));

endmodule

// File: rtl/fifo_write_logic.sv
// Write-side controller of the dual-clock FIFO: address, Gray pointer, full/almost-full.
// Optional sticky overflow flag enabled by defining FIFO_WR_OVERFLOW_EN.
module fifo_write_logic
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned PTR_SZ       = 2,
  parameter int unsigned AFULL_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ-1:0] wq2_raddr_gray,
  output logic              write_en,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ-1:0] waddr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic              wbusy,
  output logic              woverflow
);

  localparam int unsigned CW = PTR_SZ + 1;

  function automatic logic [PTR_SZ-1:0] inc_mod(input logic [PTR_SZ-1:0] a);
    return (a == PTR_SZ'(DEPTH - 1)) ? '0 : a + PTR_SZ'(1);
  endfunction

  logic [PTR_SZ-1:0] w_rbin;
  logic [PTR_SZ-1:0] w_wnext;
  logic [CW-1:0]     w_count_raw;
  logic [CW-1:0]     w_count;
  logic              w_accept;
  logic              w_full_next;
  logic              w_afull_next;
  fifo_state_e       w_state_next;

  fifo_state_e       r_state;
  logic [PTR_SZ-1:0] r_waddr;
  logic [PTR_SZ-1:0] r_waddr_gray;
  logic              r_wfull;
  logic              r_walmost_full;
  logic              r_wbusy;

  fifo_gray2bin #(.PTR_SZ(PTR_SZ)) u_rptr_dec (
    .i_gray (wq2_raddr_gray),
    .o_bin  (w_rbin)
  );

  assign w_accept = winc & ~r_wfull;
  assign write_en = w_accept;

  // Next pointer and flag values seen against the freshly synchronised read pointer.
  always_comb begin
    w_wnext      = r_waddr;
    if (w_accept) w_wnext = inc_mod(r_waddr);
    w_full_next  = (inc_mod(w_wnext) == w_rbin);
    w_count_raw  = CW'(w_wnext) + CW'(DEPTH) - CW'(w_rbin);
    w_count      = (w_count_raw >= CW'(DEPTH)) ? w_count_raw - CW'(DEPTH) : w_count_raw;
    w_afull_next = (w_count >= CW'(AFULL_THRESH));
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = WRITE;
      WRITE: begin
        if (w_full_next)   w_state_next = FULL;
        else if (w_accept) w_state_next = WRITE;
        else               w_state_next = IDLE;
      end
      FULL:    if (!w_full_next) w_state_next = winc ? WRITE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_waddr        <= '0;
      r_waddr_gray   <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wbusy        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_waddr        <= w_wnext;
      r_waddr_gray   <= PTR_SZ'(bin2gray(FIFO_PTR_MAX'(w_wnext)));
      r_wfull        <= w_full_next;
      r_walmost_full <= w_afull_next;
      r_wbusy        <= (w_state_next == WRITE);
    end
  end

  assign waddr        = r_waddr;
  assign waddr_gray   = r_waddr_gray;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wbusy        = r_wbusy;

`ifdef FIFO_WR_OVERFLOW_EN
  logic r_woverflow;

  // Sticky: a dropped write is remembered until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_woverflow <= 1'b0;
    else if (winc && r_wfull)  r_woverflow <= 1'b1;
  end

  assign woverflow = r_woverflow;
`else
  assign woverflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_logic.sv
// Self-checking bench for fifo_write_logic against an occupancy-level reference model.
module tb_fifo_write_logic;

  localparam int DEPTH = 3;
  localparam int PTR_SZ = 2;
  localparam int AFULL_THRESH = 1;
`ifdef FIFO_WR_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              winc;
  logic [PTR_SZ-1:0] wq2_raddr_gray;
  logic              write_en;
  logic [PTR_SZ-1:0] waddr;
  logic [PTR_SZ-1:0] waddr_gray;
  logic              wfull;
  logic              walmost_full;
  logic              wbusy;
  logic              woverflow;

  int checks;
  int errors;

  // Reference model: pointers as integers, mode 0=idle 1=writing 2=full.
  int m_wp, m_rp, m_mode;
  bit m_full, m_af, m_ovf, exp_we;
  logic obs_we;

  fifo_write_logic #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ), .AFULL_THRESH(AFULL_THRESH)) dut (
    .clk            (clk),
    .rst            (rst),
    .winc           (winc),
    .wq2_raddr_gray (wq2_raddr_gray),
    .write_en       (write_en),
    .waddr          (waddr),
    .waddr_gray     (waddr_gray),
    .wfull          (wfull),
    .walmost_full   (walmost_full),
    .wbusy          (wbusy),
    .woverflow      (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PTR_SZ-1:0] to_gray(input int v);
    logic [PTR_SZ-1:0] b;
    b = PTR_SZ'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_mode = 0;
    m_full = 0; m_af = 0; m_ovf = 0; exp_we = 0;
  endtask

  // Drive one cycle, sample write_en mid-cycle, advance the model, land at posedge+1.
  task automatic step(input logic w, input int rp_new);
    bit acc, nf;
    winc = w;
    wq2_raddr_gray = to_gray(rp_new);
    @(negedge clk);
    obs_we = write_en;
    exp_we = w && !m_full;
    acc = exp_we;
    if (OVF_EN && w && m_full) m_ovf = 1;
    if (acc) m_wp = (m_wp + 1) % DEPTH;
    m_rp = rp_new;
    nf = (((m_wp + 1) % DEPTH) == m_rp);
    case (m_mode)
      0: if (acc) m_mode = 1;
      1: m_mode = nf ? 2 : (acc ? 1 : 0);
      default: if (!nf) m_mode = w ? 1 : 0;
    endcase
    m_full = nf;
    m_af = (((m_wp - m_rp + DEPTH) % DEPTH) >= AFULL_THRESH);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    winc = 1'b0;
    wq2_raddr_gray = '0;
    model_reset();
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; winc = 1'b0; wq2_raddr_gray = '0;
    model_reset();
    @(posedge clk); #1;
    checks += 3;
    if (waddr !== 2'b00 || waddr_gray !== 2'b00) begin
      errors++; $display("FAIL reset_addr: waddr=%0h gray=%0h expected 0/0", waddr, waddr_gray);
    end
    if (wfull !== 1'b0 || walmost_full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: wfull=%0b afull=%0b expected 0/0", wfull, walmost_full);
    end
    if (wbusy !== 1'b0 || woverflow !== 1'b0 || write_en !== 1'b0) begin
      errors++; $display("FAIL reset_misc: busy=%0b ovf=%0b we=%0b expected 0/0/0", wbusy, woverflow, write_en);
    end
    rst = 1'b1;
    step(1, 0); step(1, 0); step(1, 0);
    checks++;
    if (woverflow !== m_ovf) begin
      errors++; $display("FAIL pre_reset_ovf: got %0b expected %0b", woverflow, m_ovf);
    end
    // Asynchronous assertion away from any clock edge.
    #2;
    rst = 1'b0; winc = 1'b0; wq2_raddr_gray = '0;
    model_reset();
    #1;
    checks += 2;
    if (waddr !== 2'b00 || waddr_gray !== 2'b00 || wfull !== 1'b0) begin
      errors++; $display("FAIL async_reset_addr: waddr=%0h gray=%0h full=%0b expected 0", waddr, waddr_gray, wfull);
    end
    if (walmost_full !== 1'b0 || wbusy !== 1'b0 || woverflow !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags: afull=%0b busy=%0b ovf=%0b expected 0", walmost_full, wbusy, woverflow);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    step(0, 0);
    checks += 2;
    if (waddr !== 2'b00 || wfull !== 1'b0 || walmost_full !== 1'b0) begin
      errors++; $display("FAIL post_release: waddr=%0h full=%0b afull=%0b expected 0", waddr, wfull, walmost_full);
    end
    if (wbusy !== 1'b0 || woverflow !== 1'b0) begin
      errors++; $display("FAIL post_release_busy: busy=%0b ovf=%0b expected 0", wbusy, woverflow);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      checks += 6;
      if (obs_we !== exp_we) begin
        errors++; $display("FAIL fill_we[%0d]: got %0b expected %0b", i, obs_we, exp_we);
      end
      if (waddr !== PTR_SZ'(m_wp)) begin
        errors++; $display("FAIL fill_waddr[%0d]: got %0h expected %0h", i, waddr, m_wp);
      end
      if (waddr_gray !== to_gray(m_wp)) begin
        errors++; $display("FAIL fill_gray[%0d]: got %0h expected %0h", i, waddr_gray, to_gray(m_wp));
      end
      if (wfull !== m_full) begin
        errors++; $display("FAIL fill_full[%0d]: got %0b expected %0b", i, wfull, m_full);
      end
      if (wbusy !== (m_mode == 1)) begin
        errors++; $display("FAIL fill_busy[%0d]: got %0b expected %0b", i, wbusy, m_mode == 1);
      end
      if (woverflow !== m_ovf) begin
        errors++; $display("FAIL fill_ovf[%0d]: got %0b expected %0b", i, woverflow, m_ovf);
      end
    end
  endtask

  task automatic test_drain();
    step(0, 1);
    checks += 2;
    if (wfull !== m_full) begin
      errors++; $display("FAIL drain_full: got %0b expected %0b", wfull, m_full);
    end
    if (walmost_full !== m_af) begin
      errors++; $display("FAIL drain_afull: got %0b expected %0b", walmost_full, m_af);
    end
    step(1, 1);
    checks += 3;
    if (obs_we !== exp_we) begin
      errors++; $display("FAIL drain_we: got %0b expected %0b", obs_we, exp_we);
    end
    if (waddr !== PTR_SZ'(m_wp)) begin
      errors++; $display("FAIL drain_wrap: got %0h expected %0h", waddr, m_wp);
    end
    if (wfull !== m_full || wbusy !== (m_mode == 1)) begin
      errors++; $display("FAIL drain_refull: full=%0b busy=%0b expected %0b/%0b", wfull, wbusy, m_full, m_mode == 1);
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    step(1, 0);
    checks++;
    if (walmost_full !== m_af) begin
      errors++; $display("FAIL afull_set: got %0b expected %0b", walmost_full, m_af);
    end
    step(0, 1);
    checks++;
    if (walmost_full !== m_af) begin
      errors++; $display("FAIL afull_clear: got %0b expected %0b", walmost_full, m_af);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1, 0); step(1, 0);
    step(1, 1);
    checks += 2;
    if (obs_we !== exp_we) begin
      errors++; $display("FAIL simul_blocked_we: got %0b expected %0b", obs_we, exp_we);
    end
    if (wfull !== m_full || waddr !== PTR_SZ'(m_wp)) begin
      errors++; $display("FAIL simul_release: full=%0b waddr=%0h expected %0b/%0h", wfull, waddr, m_full, m_wp);
    end
    step(1, 1);
    checks += 2;
    if (obs_we !== exp_we) begin
      errors++; $display("FAIL simul_accept_we: got %0b expected %0b", obs_we, exp_we);
    end
    if (wfull !== m_full || waddr !== PTR_SZ'(m_wp) || woverflow !== m_ovf) begin
      errors++; $display("FAIL simul_after: full=%0b waddr=%0h ovf=%0b expected %0b/%0h/%0b",
                         wfull, waddr, woverflow, m_full, m_wp, m_ovf);
    end
  endtask

  task automatic test_random();
    int occ, adv;
    logic w;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 3) != 0);
      occ = (m_wp - m_rp + DEPTH) % DEPTH;
      adv = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, occ)) : 0;
      step(w, (m_rp + adv) % DEPTH);
      checks += 4;
      if (obs_we !== exp_we) begin
        errors++; $display("FAIL rand_we[%0d]: got %0b expected %0b", i, obs_we, exp_we);
      end
      if (waddr !== PTR_SZ'(m_wp) || waddr_gray !== to_gray(m_wp)) begin
        errors++; $display("FAIL rand_addr[%0d]: waddr=%0h gray=%0h expected %0h/%0h",
                           i, waddr, waddr_gray, m_wp, to_gray(m_wp));
      end
      if (wfull !== m_full || walmost_full !== m_af) begin
        errors++; $display("FAIL rand_flags[%0d]: full=%0b afull=%0b expected %0b/%0b",
                           i, wfull, walmost_full, m_full, m_af);
      end
      if (wbusy !== (m_mode == 1) || woverflow !== m_ovf) begin
        errors++; $display("FAIL rand_state[%0d]: busy=%0b ovf=%0b expected %0b/%0b",
                           i, wbusy, woverflow, m_mode == 1, m_ovf);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    winc = 1'b0;
    wq2_raddr_gray = '0;
    obs_we = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_almost_full();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
